// File: rtl/sparse_route_gen.sv
// Sparse-weight routing generator: walks a latched bitmask LANES bits per
// cycle and emits per-lane one-hot routing codes. Each code is the count of
// earlier set bits in the current segment.
//
// Handshakes: a transfer occurs on a rising clk edge where valid & ready.
// A producer holds valid and its payload stable until that edge, and ready
// never waits on valid. route_* therefore depend only on registers and stay
// frozen while route_valid & ~route_ready.
module sparse_route_gen #(
  parameter  int MASK_W = 16,
  parameter  int LANES  = 4,
  parameter  int OH_W   = 10,
  parameter  int SEQ_W  = 3,
  localparam int GROUPS = MASK_W / LANES,
  localparam int GW     = $clog2(GROUPS) + 1,
  localparam int NW     = $clog2(LANES + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic [GW-1:0]         cfg_seg_grps,
  input  logic                  mask_valid,
  output logic                  mask_ready,
  input  logic [MASK_W-1:0]     mask_data,
  input  logic                  mask_last,
  output logic                  route_valid,
  input  logic                  route_ready,
  output logic [LANES*OH_W-1:0] route_onehot,
  output logic [NW-1:0]         route_nnz,
  output logic [GW-2:0]         route_grp,
  output logic [SEQ_W-1:0]      route_seq,
  output logic                  route_ovf,
  output logic                  route_last,
  output logic                  dbg_state
);

  localparam int CW = $clog2(MASK_W + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [MASK_W-1:0]       r_mask;
  logic                    r_last;
  logic [GW-1:0]           r_seg;
  logic [GW-1:0]           r_segpos;
  logic [GW-2:0]           r_grp;
  logic [CW-1:0]           r_cnt;
  logic [SEQ_W-1:0]        r_seq;

  logic                    w_final;
  logic                    w_last_hs;
  logic                    w_route_hs;
  logic                    w_mask_hs;
  logic [GW-1:0]           w_seg_eff;
  logic [LANES-1:0]        w_grp_bits;
  logic [CW-1:0]           w_run;
  logic [NW-1:0]           w_nnz;
  logic                    w_ovf;
  logic [LANES*OH_W-1:0]   w_onehot;

  assign w_final    = (r_grp == (GW-1)'(GROUPS - 1));
  assign w_last_hs  = (r_state == S_RUN) & route_ready & w_final;
  assign w_route_hs = route_valid & route_ready;
  assign w_mask_hs  = mask_valid & mask_ready;
  // Zero or oversize segment length means one segment spanning the block
  assign w_seg_eff  = ((cfg_seg_grps == '0) || (cfg_seg_grps > GW'(GROUPS)))
                      ? GW'(GROUPS) : cfg_seg_grps;
  assign w_grp_bits = r_mask[r_grp*LANES +: LANES];

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: a new mask in the final-group cycle keeps us in RUN
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_mask_hs) w_state_nxt = S_RUN;
        S_RUN:   if (w_last_hs && !w_mask_hs) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: accept a mask when idle or while the final group leaves
  always_comb begin
    route_valid = (r_state == S_RUN);
    mask_ready  = ((r_state == S_IDLE) | w_last_hs) & ~clr;
  end

  // Block registers: latch on mask accept, step group/segment count on route accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mask   <= '0;
      r_last   <= 1'b0;
      r_seg    <= '0;
      r_segpos <= '0;
      r_grp    <= '0;
      r_cnt    <= '0;
      r_seq    <= '0;
    end else if (clr) begin
      r_segpos <= '0;
      r_grp    <= '0;
      r_cnt    <= '0;
      r_seq    <= '0;
    end else begin
      if (w_route_hs) r_seq <= r_seq + SEQ_W'(1);
      if (w_mask_hs) begin
        r_mask   <= mask_data;
        r_last   <= mask_last;
        r_seg    <= w_seg_eff;
        r_segpos <= '0;
        r_grp    <= '0;
        r_cnt    <= '0;
      end else if (w_route_hs && !w_final) begin
        r_grp <= r_grp + (GW-1)'(1);
        if (r_segpos == r_seg - GW'(1)) begin
          r_segpos <= '0;
          r_cnt    <= '0;
        end else begin
          r_segpos <= r_segpos + GW'(1);
          r_cnt    <= r_cnt + CW'(w_nnz);
        end
      end
    end
  end

  // Lane decode: running prefix count inside the group selects the one-hot bit
  always_comb begin
    w_run    = r_cnt;
    w_nnz    = '0;
    w_ovf    = 1'b0;
    w_onehot = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_grp_bits[l]) begin
        if (int'(w_run) < OH_W) w_onehot[l*OH_W +: OH_W] = OH_W'(1) << w_run;
        else                    w_ovf = 1'b1;
        w_run = w_run + CW'(1);
        w_nnz = w_nnz + NW'(1);
      end
    end
  end

  assign route_onehot = route_valid ? w_onehot : '0;
  assign route_nnz    = route_valid ? w_nnz    : '0;
  assign route_ovf    = route_valid & w_ovf;
  assign route_last   = route_valid & r_last & w_final;
  assign route_grp    = r_grp;
  assign route_seq    = r_seq;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_sparse_route_gen.sv
// Directed bench for sparse_route_gen with an expected-output queue.
module tb_sparse_route_gen;

  localparam int MASK_W = 16;
  localparam int LANES  = 4;
  localparam int OH_W   = 10;
  localparam int SEQ_W  = 3;
  localparam int GROUPS = MASK_W / LANES;
  localparam int GW     = $clog2(GROUPS) + 1;
  localparam int NW     = $clog2(LANES + 1);
  localparam int EW     = LANES*OH_W + NW + (GW-1) + SEQ_W + 2;

  logic                  clk;
  logic                  rstn;
  logic                  clr;
  logic [GW-1:0]         cfg_seg_grps;
  logic                  mask_valid;
  logic                  mask_ready;
  logic [MASK_W-1:0]     mask_data;
  logic                  mask_last;
  logic                  route_valid;
  logic                  route_ready;
  logic [LANES*OH_W-1:0] route_onehot;
  logic [NW-1:0]         route_nnz;
  logic [GW-2:0]         route_grp;
  logic [SEQ_W-1:0]      route_seq;
  logic                  route_ovf;
  logic                  route_last;
  logic                  dbg_state;

  logic [EW-1:0]    exp_q[$];
  logic [SEQ_W-1:0] exp_seq;
  int               n_checks;
  int               n_errors;

  sparse_route_gen #(.MASK_W(MASK_W), .LANES(LANES), .OH_W(OH_W), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .cfg_seg_grps(cfg_seg_grps),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask_data(mask_data),
    .mask_last(mask_last), .route_valid(route_valid), .route_ready(route_ready),
    .route_onehot(route_onehot), .route_nnz(route_nnz), .route_grp(route_grp),
    .route_seq(route_seq), .route_ovf(route_ovf), .route_last(route_last),
    .dbg_state(dbg_state)
  );

  // clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: count set bits from the segment start up to each lane's bit
  function automatic logic [EW-1:0] model(input logic [MASK_W-1:0] m, input logic [GW-1:0] seg,
                                          input int g, input logic last, input logic [SEQ_W-1:0] seq);
    int s, start, cnt, b;
    logic [LANES*OH_W-1:0] oh;
    logic [NW-1:0] nnz;
    logic ovf;
    s = (seg == 0 || int'(seg) > GROUPS) ? GROUPS : int'(seg);
    start = (g / s) * s * LANES;
    oh = '0; nnz = '0; ovf = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      b = g*LANES + l;
      cnt = 0;
      for (int i = start; i < b; i++) if (m[i]) cnt++;
      if (m[b]) begin
        nnz = nnz + NW'(1);
        if (cnt < OH_W) oh[l*OH_W + cnt] = 1'b1;
        else ovf = 1'b1;
      end
    end
    return {oh, nnz, (GW-1)'(g), seq, ovf, last && (g == GROUPS-1)};
  endfunction

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input logic [MASK_W-1:0] m, input logic last, input logic [GW-1:0] seg);
    for (int g = 0; g < GROUPS; g++) begin
      exp_q.push_back(model(m, seg, g, last, exp_seq));
      exp_seq = exp_seq + SEQ_W'(1);
    end
  endtask

  // driver: called just after a rising edge, returns just after the accepting edge
  task automatic send(input logic [MASK_W-1:0] m, input logic last, input logic [GW-1:0] seg);
    logic took, rdy;
    took = 1'b0;
    mask_data = m; mask_last = last; cfg_seg_grps = seg; mask_valid = 1'b1;
    for (int guard = 0; guard < 50 && !took; guard++) begin
      @(negedge clk) rdy = mask_ready;
      @(posedge clk);
      if (rdy) begin
        took = 1'b1;
        push_block(m, last, seg);
      end
    end
    #1 mask_valid = 1'b0;
    cfg_seg_grps = GW'($urandom_range(0, 7));
    chk("send_accept", EW'(took), EW'(1));
  endtask

  task automatic drain();
    for (int guard = 0; guard < 100 && exp_q.size() != 0; guard++) @(posedge clk);
    chk("drain", EW'(exp_q.size()), EW'(0));
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every valid cycle compares against the queue head, pops on transfer
  always @(negedge clk) begin
    if (rstn && route_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", EW'(route_valid), EW'(0));
      end else begin
        chk("route", {route_onehot, route_nnz, route_grp, route_seq, route_ovf, route_last},
            exp_q[0]);
        if (route_ready && !clr) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic tk;
    int   acc_at;
    n_checks = 0; n_errors = 0; exp_seq = '0;
    rstn = 1'b0; clr = 1'b0; cfg_seg_grps = '0; mask_valid = 1'b0;
    mask_data = '0; mask_last = 1'b0; route_ready = 1'b1;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mask_ready", EW'(mask_ready), EW'(1));
    chk("rst_route_valid", EW'(route_valid), EW'(0));
    chk("rst_outputs", {route_onehot, route_nnz, route_grp, route_seq, route_ovf, route_last},
        EW'(0));
    chk("rst_state", EW'(dbg_state), EW'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: lower byte set, single segment; mask_ready returns on the 4th group
    send(16'h00FF, 1'b0, 3'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t1_ready_%0d", k), EW'(mask_ready), EW'(k == 4));
    end
    @(posedge clk);
    #1;
    drain();

    // 2: two-group segments restart the count
    send(16'hFFFF, 1'b0, 3'd2);
    drain();

    // 3: full mask overflows the one-hot width
    send(16'hFFFF, 1'b0, 3'd0);
    drain();

    // clear while idle resets the sequence
    clr = 1'b1;
    @(posedge clk);
    exp_seq = '0;
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_idle_seq", EW'(route_seq), EW'(0));
    @(posedge clk);
    #1;

    // 4: back-to-back blocks, second one accepted in the final-group cycle
    send(16'h8421, 1'b0, 3'd1);
    mask_data = 16'h1111; mask_last = 1'b1; cfg_seg_grps = 3'd1; mask_valid = 1'b1;
    acc_at = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t4_valid_%0d", k), EW'(route_valid), EW'(1));
      tk = mask_valid & mask_ready;
      @(posedge clk);
      if (tk) begin
        push_block(16'h1111, 1'b1, 3'd1);
        acc_at = k;
      end
      #1;
      if (tk) mask_valid = 1'b0;
    end
    mask_valid = 1'b0;
    chk("t4_accept_cycle", EW'(acc_at), EW'(3));
    @(negedge clk);
    chk("t4_idle", EW'(route_valid), EW'(0));
    @(posedge clk);
    #1;

    // 5: stall three cycles on group 1
    send(16'h00FF, 1'b0, 3'd0);
    @(posedge clk);
    #1 route_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 route_ready = 1'b1;
    drain();

    // 6: clear at group 2 with a competing mask
    send(16'hFFFF, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1; mask_valid = 1'b1; mask_data = 16'hABCD; mask_last = 1'b0;
    @(negedge clk);
    chk("t6_mask_ready", EW'(mask_ready), EW'(0));
    @(posedge clk);
    exp_q.delete();
    exp_seq = '0;
    #1 clr = 1'b0;
    mask_valid = 1'b0;
    @(negedge clk);
    chk("t6_valid", EW'(route_valid), EW'(0));
    chk("t6_seq", EW'(route_seq), EW'(0));
    @(posedge clk);
    #1;
    send(16'h0F0F, 1'b1, 3'd0);
    drain();

    // asynchronous reset mid-block
    send(16'hFFFF, 1'b0, 3'd0);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("arst_mask_ready", EW'(mask_ready), EW'(1));
    chk("arst_valid", EW'(route_valid), EW'(0));
    chk("arst_outputs", {route_onehot, route_nnz, route_grp, route_seq, route_ovf, route_last},
        EW'(0));
    exp_q.delete();
    exp_seq = '0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // segment lengths 3 and out-of-range 7
    send(16'hF0F7, 1'b0, 3'd3);
    drain();
    send(16'hF0F0, 1'b1, 3'd7);
    drain();
    send(MASK_W'($urandom_range(0, 65535)), 1'b0, 3'd2);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
